// File: rtl/adder.sv
// 4-bit carry-lookahead adder with registered sum and carry-out.
// Operand and sum bits are individual scalar ports; they are packed into
// vectors internally so the lookahead equations read naturally.
module adder (
  input  logic clk,
  input  logic rst_n,
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic b0,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  input  logic cin,
  output logic cout,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3
);

  localparam int unsigned W = 4;

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic [W-1:0] sum_d;
  logic [W-1:0] sum_q;
  logic         cout_d;
  logic         cout_q;

  assign a = {a3, a2, a1, a0};
  assign b = {b3, b2, b1, b0};

  // Generate/propagate terms and flattened lookahead carries (no ripple chain).
  always_comb begin
    g      = '0;
    p      = '0;
    c      = '0;
    sum_d  = '0;
    cout_d = 1'b0;

    g = a & b;
    p = a ^ b;

    c[0] = cin;
    c[1] = g[0]
         | (p[0] & cin);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & cin);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);

    sum_d  = p ^ c[W-1:0];
    cout_d = c[W];
  end

  // Result register; async reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign cout = cout_q;
  assign s0   = sum_q[0];
  assign s1   = sum_q[1];
  assign s2   = sum_q[2];
  assign s3   = sum_q[3];

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for the 4-bit registered adder.
module tb_adder;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       cout;
  logic       s0, s1, s2, s3;

  typedef struct {
    int    exp;
    string name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a0   (a[0]),
    .a1   (a[1]),
    .a2   (a[2]),
    .a3   (a[3]),
    .b0   (b[0]),
    .b1   (b[1]),
    .b2   (b[2]),
    .b3   (b[3]),
    .cin  (cin),
    .cout (cout),
    .s0   (s0),
    .s1   (s1),
    .s2   (s2),
    .s3   (s3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dut_out();
    return int'({cout, s3, s2, s1, s0});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one operand set just after a falling edge and record what the
  // next rising edge must produce: the plain sum, or zero while in reset.
  task automatic step(input int av, input int bv, input int cv, input bit rv,
                      input string name);
    exp_t e;
    @(negedge clk);
    a     = 4'(av);
    b     = 4'(bv);
    cin   = cv[0];
    rst_n = rv;
    e.exp  = rv ? (av + bv + cv) : 0;
    e.name = name;
    q.push_back(e);
  endtask

  // Scramble inputs between edges; the captured value must not move.
  task automatic hold_check(input int exp);
    @(posedge clk);
    #2;
    a   = 4'($urandom_range(15));
    b   = 4'($urandom_range(15));
    cin = 1'($urandom_range(1));
    #2;
    chk("hold", dut_out(), exp);
  endtask

  // Monitor: every rising edge with a pending expectation is checked.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, dut_out(), e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kk;
    int av, bv;
    int rv;
    int waited;

    rst_n = 1'b0;
    a     = 4'hF;
    b     = 4'hF;
    cin   = 1'b1;
    #1;
    chk("reset_state", dut_out(), 0);

    // Held in reset with max operands and clock running.
    for (int i = 0; i < 4; i++) step(15, 15, 1, 1'b0, "reset_hold");
    step(15, 15, 1, 1'b1, "reset_release");
    #1;
    chk("deassert_no_change", dut_out(), 0);

    // Directed values.
    step(0, 0, 0, 1'b1, "zero");
    step(5, 10, 0, 1'b1, "alt_nocarry");
    hold_check(15);
    step(5, 10, 1, 1'b1, "alt_carry");
    step(15, 1, 0, 1'b1, "carry_full");
    step(7, 1, 0, 1'b1, "carry_partial");
    hold_check(8);
    step(15, 15, 1, 1'b1, "max");

    // Async reset between edges while outputs are non-zero.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_assert", dut_out(), 0);
    step(9, 9, 1, 1'b0, "reset_discard");
    step(9, 9, 1, 1'b1, "post_reset_load");
    #1;
    chk("deassert_no_change2", dut_out(), 0);
    step(3, 4, 0, 1'b1, "after_release");

    // Exhaustive interleaved-bit sweep, k = 256 wraps to zero.
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k <= 256; k++) begin
        kk = k % 256;
        av = ((kk >> 7) & 1) * 8 + ((kk >> 5) & 1) * 4 + ((kk >> 3) & 1) * 2 + ((kk >> 1) & 1);
        bv = ((kk >> 6) & 1) * 8 + ((kk >> 4) & 1) * 4 + ((kk >> 2) & 1) * 2 + (kk & 1);
        step(av, bv, c, 1'b1, "sweep");
      end
    end

    // Random operands with occasional reset pulses.
    for (int i = 0; i < 200; i++) begin
      rv = ($urandom_range(19) == 0) ? 0 : 1;
      step(int'($urandom_range(15)), int'($urandom_range(15)),
           int'($urandom_range(1)), rv[0], "random");
    end
    step(0, 0, 0, 1'b1, "final");

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
